// File: rtl/mac8_dot_seq.sv
// rtl/mac8_dot_seq.sv - sequencer feeding an external 8x8 MAC to compute one dot product per job
module mac8_dot_seq #(
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    abort,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic signed [7:0]       op_a,
    input  logic signed [7:0]       op_b,
    output logic signed [7:0]       mac_a,
    output logic signed [7:0]       mac_b,
    output logic                    mac_en,
    output logic                    mac_clr,
    input  logic signed [31:0]      mac_acc,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [31:0]      res_data,
    output logic                    busy,
    output logic                    err_len,
    output logic [LEN_W-1:0]        beats_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beats_q;
    logic [LEN_W-1:0]   beats_inc;
    logic signed [31:0] res_q;
    logic               err_q;
    logic               in_idle;
    logic               kill;
    logic               accept_start;
    logic               last_beat;

    assign in_idle      = (state == S_IDLE);
    // abort only acts on an active job; in IDLE it is ignored entirely
    assign kill         = abort && !in_idle;
    assign accept_start = in_idle && start && (len != '0);
    assign beats_inc    = beats_q + {{(LEN_W-1){1'b0}}, 1'b1};
    assign last_beat    = mac_en && (beats_inc == len_q);

    assign res_data   = res_q;
    assign err_len    = err_q;
    assign beats_done = beats_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; abort masks op_ready/res_valid so a
    // coincident beat or result handshake is never counted
    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        mac_clr   = 1'b0;
        busy      = !in_idle;
        case (state)
            S_IDLE: begin
                if (accept_start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clr   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                op_ready = !abort;
                if (last_beat) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                res_valid = !abort;
                if (res_ready && !abort) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (kill) begin
            mac_clr   = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    // MAC operand gating: operands are zeroed whenever no beat is accepted
    always_comb begin
        mac_en = op_valid && op_ready;
        mac_a  = mac_en ? op_a : 8'sd0;
        mac_b  = mac_en ? op_b : 8'sd0;
    end

    // Job bookkeeping: latched length, beat counter, result capture, length error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            beats_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= in_idle && start && (len == '0);
            if (accept_start) begin
                len_q   <= len;
                beats_q <= '0;
            end else if (mac_en) begin
                beats_q <= beats_inc;
            end
            // mac_acc already holds the final beat when DRAIN is reached
            if (state == S_DRAIN && !abort) begin
                res_q <= mac_acc;
            end
        end
    end

endmodule

// File: tb/tb_mac8_dot_seq.sv
// tb/tb_mac8_dot_seq.sv - self-checking bench for mac8_dot_seq with a behavioural MAC and result scoreboard
module tb_mac8_dot_seq;

    localparam int LEN_W = 16;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    abort;
    logic                    op_valid;
    logic                    op_ready;
    logic signed [7:0]       op_a;
    logic signed [7:0]       op_b;
    logic signed [7:0]       mac_a;
    logic signed [7:0]       mac_b;
    logic                    mac_en;
    logic                    mac_clr;
    logic signed [31:0]      mac_acc;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [31:0]      res_data;
    logic                    busy;
    logic                    err_len;
    logic [LEN_W-1:0]        beats_done;

    int n_vec = 0;
    int n_err = 0;

    logic signed [7:0]  qa[$];
    logic signed [7:0]  qb[$];
    logic signed [31:0] sb[$];

    mac8_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .mac_acc    (mac_acc),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .err_len    (err_len),
        .beats_done (beats_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External MAC: not reset, so only mac_clr can bring it to zero
    logic signed [31:0] ext_a;
    logic signed [31:0] ext_b;
    assign ext_a = mac_a;
    assign ext_b = mac_b;
    initial mac_acc = 32'sh1234_5678;
    always @(posedge clk) begin
        if (mac_clr) mac_acc <= 32'sd0;
        else if (mac_en) mac_acc <= mac_acc + ext_a * ext_b;
    end

    function automatic logic signed [31:0] dot_ref();
        logic signed [31:0] s;
        s = 32'sd0;
        for (int i = 0; i < qa.size(); i++) s = s + 32'(int'(qa[i]) * int'(qb[i]));
        return s;
    endfunction

    // Drives start at the current negedge and feeds qa/qb; returns the cycle
    // (counted in negedges after start) at which res_valid appears, or -1
    task automatic run_job(input int len_i, input int toggle, output int cyc_valid);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        cyc_valid = -1;
        start = 1'b1;
        len = len_i[LEN_W-1:0];
        op_valid = 1'b0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (idx < qa.size() && (toggle == 0 || cyc[0] == 1'b0)) begin
                op_valid = 1'b1;
                op_a = qa[idx];
                op_b = qb[idx];
            end else begin
                op_valid = 1'b0;
                op_a = 8'sd0;
                op_b = 8'sd0;
            end
            #1;
            if (res_valid) begin
                cyc_valid = cyc;
                op_valid = 1'b0;
                break;
            end
            if (op_ready && op_valid) idx++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        len = 16'd3;
        abort = 1'b0;
        op_valid = 1'b1;
        op_a = 8'sd5;
        op_b = 8'sd6;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({busy, op_ready, mac_en, mac_clr, res_valid, err_len} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000", {busy, op_ready, mac_en, mac_clr, res_valid, err_len});
        end
        n_vec++;
        if ({mac_a, mac_b} !== 16'h0 || res_data !== 32'sd0 || beats_done !== '0) begin
            n_err++;
            $display("FAIL reset_data: mac_a %0d mac_b %0d res %0d beats %0d expected all 0", mac_a, mac_b, res_data, beats_done);
        end
        start = 1'b0;
        op_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        logic signed [31:0] exp_v;
        qa = '{8'sd2, -8'sd4, 8'sd127};
        qb = '{8'sd3, 8'sd5, 8'sd127};
        sb.push_back(dot_ref());
        run_job(3, 0, cyc);
        n_vec++;
        if (cyc !== 6) begin
            n_err++;
            $display("FAIL basic_latency: got %0d expected 6", cyc);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (res_data !== exp_v || exp_v !== 32'sd16115) begin
            n_err++;
            $display("FAIL basic_result: got %0d expected %0d", res_data, exp_v);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle: busy %b res_valid %b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_gaps();
        int cyc;
        logic signed [31:0] exp_v;
        qa = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        qb = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        sb.push_back(dot_ref());
        run_job(4, 1, cyc);
        n_vec++;
        if (cyc < 0) begin
            n_err++;
            $display("FAIL gaps_timeout: got %0d expected res_valid", cyc);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (res_data !== exp_v || exp_v !== 32'sd65536) begin
            n_err++;
            $display("FAIL gaps_result: got %0d expected %0d", res_data, exp_v);
        end
        n_vec++;
        if (beats_done !== 16'd4) begin
            n_err++;
            $display("FAIL gaps_beats: got %0d expected 4", beats_done);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        start = 1'b1;
        len = 16'd0;
        #1;
        n_vec++;
        if (mac_clr !== 1'b0 || err_len !== 1'b0) begin
            n_err++;
            $display("FAIL lenz_start: mac_clr %b err_len %b expected 0 0", mac_clr, err_len);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_vec++;
        if (err_len !== 1'b1 || busy !== 1'b0 || mac_clr !== 1'b0) begin
            n_err++;
            $display("FAIL lenz_pulse: err_len %b busy %b mac_clr %b expected 1 0 0", err_len, busy, mac_clr);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (err_len !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL lenz_end: err_len %b busy %b expected 0 0", err_len, busy);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic signed [31:0] exp_v;
        qa = '{8'sd10, 8'sd7};
        qb = '{-8'sd20, 8'sd7};
        sb.push_back(dot_ref());
        run_job(2, 0, cyc);
        exp_v = sb.pop_front();
        n_vec++;
        if (res_data !== exp_v || exp_v !== -32'sd151) begin
            n_err++;
            $display("FAIL bp_result: got %0d expected %0d", res_data, exp_v);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 3);
            len = 16'd5;
            #1;
            n_vec++;
            if (res_valid !== 1'b1 || res_data !== exp_v || beats_done !== 16'd2 || mac_clr !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid %b data %0d beats %0d clr %b expected 1 %0d 2 0", i, res_valid, res_data, beats_done, mac_clr, exp_v);
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: busy %b res_valid %b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_abort();
        int cyc;
        logic signed [31:0] exp_v;
        start = 1'b1;
        len = 16'd5;
        op_valid = 1'b1;
        op_a = 8'sd9;
        op_b = 8'sd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        #1;
        n_vec++;
        if (beats_done !== 16'd2) begin
            n_err++;
            $display("FAIL abort_beats_before: got %0d expected 2", beats_done);
        end
        n_vec++;
        if (mac_clr !== 1'b1 || mac_en !== 1'b0) begin
            n_err++;
            $display("FAIL abort_cycle: mac_clr %b mac_en %b expected 1 0", mac_clr, mac_en);
        end
        @(negedge clk);
        abort = 1'b0;
        op_valid = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || beats_done !== 16'd2 || op_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: busy %b beats %0d op_ready %b expected 0 2 0", busy, beats_done, op_ready);
        end
        abort = 1'b1;
        #1;
        n_vec++;
        if (mac_clr !== 1'b0) begin
            n_err++;
            $display("FAIL abort_in_idle: mac_clr %b expected 0", mac_clr);
        end
        @(negedge clk);
        abort = 1'b0;
        qa = '{8'sd3};
        qb = '{-8'sd3};
        sb.push_back(dot_ref());
        run_job(1, 0, cyc);
        n_vec++;
        if (cyc !== 4) begin
            n_err++;
            $display("FAIL abort_next_latency: got %0d expected 4", cyc);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (res_data !== exp_v || exp_v !== -32'sd9) begin
            n_err++;
            $display("FAIL abort_next_result: got %0d expected %0d", res_data, exp_v);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic signed [31:0] exp_v;
        start = 1'b1;
        len = 16'd4;
        op_valid = 1'b1;
        op_a = 8'sd50;
        op_b = 8'sd50;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, op_ready, mac_en, mac_clr, res_valid, err_len} !== 6'b0) begin
            n_err++;
            $display("FAIL rstrun_ctrl: got %b expected 000000", {busy, op_ready, mac_en, mac_clr, res_valid, err_len});
        end
        n_vec++;
        if ({mac_a, mac_b} !== 16'h0 || res_data !== 32'sd0 || beats_done !== '0) begin
            n_err++;
            $display("FAIL rstrun_data: mac_a %0d mac_b %0d res %0d beats %0d expected all 0", mac_a, mac_b, res_data, beats_done);
        end
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        qa = '{8'sd5, -8'sd7};
        qb = '{8'sd6, 8'sd2};
        sb.push_back(dot_ref());
        run_job(2, 0, cyc);
        n_vec++;
        if (cyc !== 5) begin
            n_err++;
            $display("FAIL rstrun_latency: got %0d expected 5", cyc);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (res_data !== exp_v || exp_v !== 32'sd16) begin
            n_err++;
            $display("FAIL rstrun_result: got %0d expected %0d", res_data, exp_v);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_len_zero();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac8_dot_seq.md
MAC8_DOT_SEQ -- requirements
Module: mac8_dot_seq

Interface
REQ-001 Parameter LEN_W, default 16: width of the dot-product length and beat counters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin one dot product; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of operand pairs, unsigned, latched on accepted start.
REQ-006 abort  input  1  synchronous cancel of the current job.
REQ-007 op_valid  input  1  operand pair present.
REQ-008 op_ready  output  1  sequencer accepts the operand pair this cycle.
REQ-009 op_a, op_b  input  8 each  signed operands.
REQ-010 mac_a, mac_b  output  8 each  signed operands to the MAC.
REQ-011 mac_en  output  1  MAC accumulate enable.
REQ-012 mac_clr  output  1  MAC synchronous clear.
REQ-013 mac_acc  input  32  signed MAC accumulator, updated on the clock edge after mac_en or mac_clr.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  result consumer accepts.
REQ-016 res_data  output  32  signed dot-product result.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err_len  output  1  one-cycle pulse on start with len==0.
REQ-019 beats_done  output  LEN_W  operand pairs accepted in the current job.

Function
REQ-020 The block SHALL implement the states IDLE, CLEAR, RUN, DRAIN and OUT.
REQ-021 In IDLE, start with nonzero len SHALL latch len, zero beats_done and go to CLEAR.
REQ-022 In IDLE, start with len==0 SHALL pulse err_len the next cycle and remain in IDLE.
REQ-023 In any state other than IDLE, start SHALL be ignored.
REQ-024 CLEAR SHALL last exactly one cycle with mac_clr=1 and mac_en=0, then go to RUN.
REQ-025 In RUN, op_ready SHALL be 1 and 0 in all other states.
REQ-026 mac_en SHALL equal op_valid AND op_ready, combinationally.
REQ-027 mac_a and mac_b SHALL equal op_a and op_b when mac_en=1, and 0 otherwise.
REQ-028 Each accepted beat SHALL increment beats_done by 1.
REQ-029 After the beat that makes beats_done equal the latched len, the block SHALL go to DRAIN and assert op_ready no further.
REQ-030 DRAIN SHALL last one cycle, capture mac_acc into res_data, then go to OUT.
REQ-031 In OUT, res_valid SHALL be 1; res_data SHALL hold stable until res_valid AND res_ready.
REQ-032 On res_valid AND res_ready in OUT, the block SHALL go to IDLE on the next edge.
REQ-033 Gaps in op_valid SHALL stall RUN without loss or duplication of beats.
REQ-034 abort in any non-IDLE state SHALL force IDLE on the next edge, drive mac_clr=1 in the abort cycle and drop res_valid.
REQ-035 When abort and res_ready/op_valid coincide, abort SHALL win and no beat or result SHALL be counted.
REQ-036 abort in IDLE SHALL have no effect.
REQ-037 The accumulation SHALL wrap modulo 2^32 with no saturation; zero operands SHALL be passed through unchanged.
REQ-038 Latency from an accepted start to res_valid SHALL be len+3 cycles when op_valid is held high.

Reset
REQ-039 While rst_n=0, state SHALL be IDLE and op_ready, mac_en, mac_clr, res_valid, busy and err_len SHALL be 0.
REQ-040 While rst_n=0, mac_a, mac_b, res_data and beats_done SHALL be 0.
REQ-041 Reset asserted mid-job SHALL discard the job; the first job after reset SHALL begin with CLEAR.

Verification
REQ-042 len=3, pairs (2,3), (-4,5), (127,127), op_valid held high -> res_data=16115, res_valid on cycle 6 after start.
REQ-043 len=4, all pairs (-128,-128), op_valid toggling 1,0,1,0 -> res_data=65536 and beats_done=4.
REQ-044 start with len=0 -> err_len high for exactly one cycle, busy stays 0, no mac_clr.
REQ-045 res_ready held low for 10 cycles with a second start pulse in between -> res_data stable, second start ignored, IDLE after the handshake.
REQ-046 abort after 2 of 5 beats -> mac_clr=1 in the abort cycle, IDLE next cycle; a following len=1 job with (3,-3) -> res_data=-9.
REQ-047 rst_n pulsed low mid-RUN -> all outputs 0 immediately; next job computes correctly from 0.
